rvx_memory_port_arbiter: RTL and testbench
==========================================

# rvx_memory_port_arbiter

Shares a single 32-bit memory port between the core's instruction bus (read-only) and data bus (read/write), so an RVX core can run from one unified memory. Sits between the core's ibus/dbus ports and the memory or interconnect. At most one transaction is outstanding at a time. Downstream request signals are registered; responses and read data are routed back only to the requester that owns the transaction.

## Interface

- No parameters. All data and address widths are fixed at 32 bits.

Ports:
- clock  in  1  — single clock; all state updates on the rising edge.
- reset  in  1  — asynchronous, active-high reset.
- ibus_address  in  32  — instruction fetch address.
- ibus_rrequest  in  1  — fetch request.
- ibus_rdata  out  32  — fetch data.
- ibus_rresponse  out  1  — fetch complete.
- dbus_address  in  32  — data access address.
- dbus_rrequest  in  1  — data read request.
- dbus_wrequest  in  1  — data write request.
- dbus_wdata  in  32  — write data.
- dbus_wstrobe  in  4  — byte enables.
- dbus_rdata  out  32  — read data.
- dbus_rresponse  out  1  — read complete.
- dbus_wresponse  out  1  — write complete.
- mem_address  out  32  — registered, latched at grant.
- mem_rrequest  out  1  — registered.
- mem_wrequest  out  1  — registered.
- mem_wdata  out  32  — registered.
- mem_wstrobe  out  4  — registered.
- mem_rdata  in  32  — memory read data.
- mem_rresponse  in  1  — memory read complete.
- mem_wresponse  in  1  — memory write complete.

## Operation

- States: IDLE, IBUS_BUSY, DBUS_BUSY. A last_grant bit records the most recent owner (0 = ibus, 1 = dbus).
- Request definitions: ibus_req = ibus_rrequest; dbus_req = dbus_rrequest | dbus_wrequest.
- Requester rules:
  - A requester holds its request and address/data stable until it sees its response.
  - In the cycle after the response it must deassert or present a new transaction.
  - A dbus read and write are never asserted together. If both are, both are forwarded and either memory response completes the transaction.
- IDLE:
  - If any request is present, grant it (see arbitration below).
  - On grant, latch the winner's address/rrequest/wrequest/wdata/wstrobe into the mem_* registers and move to the corresponding BUSY state.
  - For an ibus grant: mem_wrequest=0, mem_wdata=0, mem_wstrobe=0.
- BUSY:
  - mem_* outputs are held until done = mem_rresponse | mem_wresponse.
  - The done cycle is forwarded combinationally to the owner only.
- On done:
  - If the non-owner is requesting, grant it directly (back-to-back, no IDLE cycle).
  - Otherwise clear mem_rrequest/mem_wrequest and return to IDLE.
  - The owner's request in the done cycle is stale and is ignored.
- Response routing:
  - ibus_rresponse = mem_rresponse & IBUS_BUSY.
  - dbus_rresponse = mem_rresponse & DBUS_BUSY.
  - dbus_wresponse = mem_wresponse & DBUS_BUSY.
- Read data: ibus_rdata and dbus_rdata both equal mem_rdata at all times. They are qualified only by the response signals.
- Responses arriving in IDLE are ignored and produce no output response.
- Arbitration in IDLE with both requesting: see Configuration.

## Timing

- Reset values: state=IDLE, last_grant=0, all mem_* outputs 0. All response outputs are 0, since they are combinational from IDLE.
- Arbitration latency: a request seen in IDLE at edge N appears on mem_* from edge N+1.
- A memory response in the same cycle as the memory request gives a 2-cycle round trip as seen by the requester.
- Back-to-back grants: the next transaction appears on mem_* in the cycle after done, with no gap.
- Reset asserted mid-transaction: immediate return to IDLE and all mem_* cleared. A late memory response after reset release is ignored.
- Address, data and strobe pass through unmodified. There is no alignment checking.

## Configuration

- RVX_ARBITER_ROUND_ROBIN_EN defined:
  - When both request in IDLE, grant the requester that is not last_grant.
  - last_grant updates on every grant, including direct hand-offs.
- Undefined: fixed priority, with dbus winning in IDLE. last_grant is still maintained but has no effect.
- Hand-off on done always goes to the non-owner in both configurations.

## Test plan

- Single ibus fetch 0x00000100, with memory responding one cycle after mem_rrequest and rdata=0x00000013:
  - mem_rrequest=1 and mem_address=0x100 at edge+1.
  - ibus_rresponse=1 with rdata 0x13.
  - dbus_rresponse stays 0.
- dbus write to 0x2000 with wdata 0xDEADBEEF, wstrobe 0xF:
  - mem_wrequest=1 with latched values.
  - dbus_wresponse pulses on mem_wresponse.
  - mem_wrequest=0 in the following cycle.
- Simultaneous ibus and dbus requests in IDLE:
  - Without the macro: dbus is granted first, ibus is handed off back-to-back on done.
  - With the macro, after a prior dbus grant: ibus is granted first.
- Continuous ibus requests with a dbus request arriving mid-fetch: dbus is granted in the cycle after the ibus done cycle, with no IDLE gap.
- Reset asserted while DBUS_BUSY, then a mem_wresponse after reset release:
  - All mem_* are 0 immediately.
  - No dbus_wresponse is produced.
  - State is IDLE.
- mem_rresponse pulsed in IDLE: no ibus/dbus response, and state is unchanged.

Source files
------------

// File: rtl/rvx_memory_port_arbiter.sv
// rvx_memory_port_arbiter
//
// Shares one 32-bit memory port between the instruction bus (read-only) and
// the data bus (read/write). Only one transaction is outstanding at a time.
// Downstream request signals are registered and latched at grant. Responses
// are routed combinationally back to the requester that owns the transaction.
//
// Optional feature macro: RVX_ARBITER_ROUND_ROBIN_EN
//   defined   : when both buses request in IDLE, the bus that did not win
//               the last grant is granted.
//   undefined : fixed priority, dbus wins in IDLE.
//   In both builds, completion of a transaction hands the port straight to the
//   other bus when that bus is requesting.
//
// Ports
//   clock, reset          : clock and asynchronous active-high reset
//   ibus_*                : instruction fetch request / response
//   dbus_*                : data read/write request / response
//   mem_address/rrequest/wrequest/wdata/wstrobe : registered memory request
//   mem_rdata/rresponse/wresponse               : memory response
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | no transaction outstanding, arbitrating new requests
// IBUS_BUSY  | ibus owns the memory port, waiting for completion
// DBUS_BUSY  | dbus owns the memory port, waiting for completion

module rvx_memory_port_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] ibus_address,
    input  logic        ibus_rrequest,
    output logic [31:0] ibus_rdata,
    output logic        ibus_rresponse,

    input  logic [31:0] dbus_address,
    input  logic        dbus_rrequest,
    input  logic        dbus_wrequest,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_wstrobe,
    output logic [31:0] dbus_rdata,
    output logic        dbus_rresponse,
    output logic        dbus_wresponse,

    output logic [31:0] mem_address,
    output logic        mem_rrequest,
    output logic        mem_wrequest,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrobe,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rresponse,
    input  logic        mem_wresponse
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        IBUS_BUSY = 2'd1,
        DBUS_BUSY = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic        mem_rrequest_q, mem_rrequest_d;
    logic        mem_wrequest_q, mem_wrequest_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrobe_q, mem_wstrobe_d;

    logic        ibus_req;
    logic        dbus_req;
    logic        done;
    logic        grant_ibus;
    logic        grant_dbus;
    logic        go_idle;

    assign ibus_req = ibus_rrequest;
    assign dbus_req = dbus_rrequest | dbus_wrequest;
    assign done     = mem_rresponse | mem_wresponse;

    always_comb begin
        grant_ibus = 1'b0;
        grant_dbus = 1'b0;
        go_idle    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ibus_req && dbus_req) begin
`ifdef RVX_ARBITER_ROUND_ROBIN_EN
                    if (last_grant_q) grant_ibus = 1'b1;
                    else              grant_dbus = 1'b1;
`else
                    grant_dbus = 1'b1;
`endif
                end else if (dbus_req) begin
                    grant_dbus = 1'b1;
                end else if (ibus_req) begin
                    grant_ibus = 1'b1;
                end
            end
            // The owner's own request in the done cycle is stale, so only the
            // other bus is considered for a direct hand-off.
            IBUS_BUSY: begin
                if (done) begin
                    if (dbus_req) grant_dbus = 1'b1;
                    else          go_idle    = 1'b1;
                end
            end
            DBUS_BUSY: begin
                if (done) begin
                    if (ibus_req) grant_ibus = 1'b1;
                    else          go_idle    = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        mem_address_d  = mem_address_q;
        mem_rrequest_d = mem_rrequest_q;
        mem_wrequest_d = mem_wrequest_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrobe_d  = mem_wstrobe_q;

        if (grant_ibus) begin
            state_d        = IBUS_BUSY;
            last_grant_d   = 1'b0;
            mem_address_d  = ibus_address;
            mem_rrequest_d = 1'b1;
            mem_wrequest_d = 1'b0;
            mem_wdata_d    = 32'd0;
            mem_wstrobe_d  = 4'd0;
        end else if (grant_dbus) begin
            state_d        = DBUS_BUSY;
            last_grant_d   = 1'b1;
            mem_address_d  = dbus_address;
            mem_rrequest_d = dbus_rrequest;
            mem_wrequest_d = dbus_wrequest;
            mem_wdata_d    = dbus_wdata;
            mem_wstrobe_d  = dbus_wstrobe;
        end else if (go_idle) begin
            state_d        = IDLE;
            mem_rrequest_d = 1'b0;
            mem_wrequest_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            last_grant_q   <= 1'b0;
            mem_address_q  <= 32'd0;
            mem_rrequest_q <= 1'b0;
            mem_wrequest_q <= 1'b0;
            mem_wdata_q    <= 32'd0;
            mem_wstrobe_q  <= 4'd0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            mem_address_q  <= mem_address_d;
            mem_rrequest_q <= mem_rrequest_d;
            mem_wrequest_q <= mem_wrequest_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrobe_q  <= mem_wstrobe_d;
        end
    end

    assign mem_address  = mem_address_q;
    assign mem_rrequest = mem_rrequest_q;
    assign mem_wrequest = mem_wrequest_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrobe  = mem_wstrobe_q;

    // Read data is shared; the response strobes decide who consumes it.
    assign ibus_rdata     = mem_rdata;
    assign dbus_rdata     = mem_rdata;
    assign ibus_rresponse = mem_rresponse & (state_q == IBUS_BUSY);
    assign dbus_rresponse = mem_rresponse & (state_q == DBUS_BUSY);
    assign dbus_wresponse = mem_wresponse & (state_q == DBUS_BUSY);

endmodule

// File: tb/tb_rvx_memory_port_arbiter.sv
module tb_rvx_memory_port_arbiter;

    logic        clock;
    logic        reset;
    logic [31:0] ibus_address;
    logic        ibus_rrequest;
    logic [31:0] ibus_rdata;
    logic        ibus_rresponse;
    logic [31:0] dbus_address;
    logic        dbus_rrequest;
    logic        dbus_wrequest;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_wstrobe;
    logic [31:0] dbus_rdata;
    logic        dbus_rresponse;
    logic        dbus_wresponse;
    logic [31:0] mem_address;
    logic        mem_rrequest;
    logic        mem_wrequest;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrobe;
    logic [31:0] mem_rdata;
    logic        mem_rresponse;
    logic        mem_wresponse;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] ST_IDLE = 32'd0;

    rvx_memory_port_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .ibus_address   (ibus_address),
        .ibus_rrequest  (ibus_rrequest),
        .ibus_rdata     (ibus_rdata),
        .ibus_rresponse (ibus_rresponse),
        .dbus_address   (dbus_address),
        .dbus_rrequest  (dbus_rrequest),
        .dbus_wrequest  (dbus_wrequest),
        .dbus_wdata     (dbus_wdata),
        .dbus_wstrobe   (dbus_wstrobe),
        .dbus_rdata     (dbus_rdata),
        .dbus_rresponse (dbus_rresponse),
        .dbus_wresponse (dbus_wresponse),
        .mem_address    (mem_address),
        .mem_rrequest   (mem_rrequest),
        .mem_wrequest   (mem_wrequest),
        .mem_wdata      (mem_wdata),
        .mem_wstrobe    (mem_wstrobe),
        .mem_rdata      (mem_rdata),
        .mem_rresponse  (mem_rresponse),
        .mem_wresponse  (mem_wresponse)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [31:0] first_addr, second_addr;
    logic        first_is_dbus;

    initial begin
        reset         = 1'b1;
        ibus_address  = 32'd0;
        ibus_rrequest = 1'b0;
        dbus_address  = 32'd0;
        dbus_rrequest = 1'b0;
        dbus_wrequest = 1'b0;
        dbus_wdata    = 32'd0;
        dbus_wstrobe  = 4'd0;
        mem_rdata     = 32'd0;
        mem_rresponse = 1'b0;
        mem_wresponse = 1'b0;

        tick();
        chk_eq("rst_mem_address", mem_address, 32'd0);
        chk_eq("rst_mem_rrequest", 32'(mem_rrequest), 32'd0);
        chk_eq("rst_mem_wrequest", 32'(mem_wrequest), 32'd0);
        chk_eq("rst_mem_wdata", mem_wdata, 32'd0);
        chk_eq("rst_mem_wstrobe", 32'(mem_wstrobe), 32'd0);
        chk_eq("rst_responses", 32'({ibus_rresponse, dbus_rresponse, dbus_wresponse}), 32'd0);
        chk_eq("rst_state", 32'(dut.state_q), ST_IDLE);
        reset = 1'b0;
        tick();

        // single ibus fetch
        ibus_address  = 32'h0000_0100;
        ibus_rrequest = 1'b1;
        tick();
        chk_eq("if_mem_rrequest", 32'(mem_rrequest), 32'd1);
        chk_eq("if_mem_address", mem_address, 32'h0000_0100);
        chk_eq("if_mem_wrequest", 32'(mem_wrequest), 32'd0);
        chk_eq("if_no_early_resp", 32'(ibus_rresponse), 32'd0);
        tick();
        mem_rresponse = 1'b1;
        mem_rdata     = 32'h0000_0013;
        #1;
        chk_eq("if_ibus_rresponse", 32'(ibus_rresponse), 32'd1);
        chk_eq("if_ibus_rdata", ibus_rdata, 32'h0000_0013);
        chk_eq("if_dbus_rresponse", 32'(dbus_rresponse), 32'd0);
        tick();
        ibus_rrequest = 1'b0;
        mem_rresponse = 1'b0;
        chk_eq("if_mem_rrequest_clr", 32'(mem_rrequest), 32'd0);
        chk_eq("if_state_idle", 32'(dut.state_q), ST_IDLE);

        // dbus write
        dbus_address  = 32'h0000_2000;
        dbus_wdata    = 32'hDEAD_BEEF;
        dbus_wstrobe  = 4'hF;
        dbus_wrequest = 1'b1;
        tick();
        chk_eq("wr_mem_wrequest", 32'(mem_wrequest), 32'd1);
        chk_eq("wr_mem_rrequest", 32'(mem_rrequest), 32'd0);
        chk_eq("wr_mem_address", mem_address, 32'h0000_2000);
        chk_eq("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk_eq("wr_mem_wstrobe", 32'(mem_wstrobe), 32'hF);
        mem_wresponse = 1'b1;
        #1;
        chk_eq("wr_dbus_wresponse", 32'(dbus_wresponse), 32'd1);
        chk_eq("wr_other_resp", 32'({ibus_rresponse, dbus_rresponse}), 32'd0);
        tick();
        dbus_wrequest = 1'b0;
        mem_wresponse = 1'b0;
        chk_eq("wr_mem_wrequest_clr", 32'(mem_wrequest), 32'd0);

        // simultaneous requests; last grant was dbus
        ibus_address  = 32'h0000_0200;
        ibus_rrequest = 1'b1;
        dbus_address  = 32'h0000_3000;
        dbus_wdata    = 32'h1234_5678;
        dbus_wstrobe  = 4'h5;
        dbus_rrequest = 1'b1;
`ifdef RVX_ARBITER_ROUND_ROBIN_EN
        first_is_dbus = 1'b0;
`else
        first_is_dbus = 1'b1;
`endif
        first_addr  = first_is_dbus ? 32'h0000_3000 : 32'h0000_0200;
        second_addr = first_is_dbus ? 32'h0000_0200 : 32'h0000_3000;
        tick();
        chk_eq("sim_first_addr", mem_address, first_addr);
        chk_eq("sim_first_rreq", 32'(mem_rrequest), 32'd1);
        mem_rresponse = 1'b1;
        mem_rdata     = 32'hAAAA_5555;
        #1;
        chk_eq("sim_first_resp", 32'({ibus_rresponse, dbus_rresponse}),
               first_is_dbus ? 32'd1 : 32'd2);
        chk_eq("sim_first_rdata", first_is_dbus ? dbus_rdata : ibus_rdata, 32'hAAAA_5555);
        tick();
        mem_rresponse = 1'b0;
        if (first_is_dbus) dbus_rrequest = 1'b0;
        else               ibus_rrequest = 1'b0;
        chk_eq("sim_handoff_addr", mem_address, second_addr);
        chk_eq("sim_handoff_rreq", 32'(mem_rrequest), 32'd1);
        chk_eq("sim_handoff_wdata", mem_wdata, first_is_dbus ? 32'd0 : 32'h1234_5678);
        chk_eq("sim_handoff_wstrobe", 32'(mem_wstrobe), first_is_dbus ? 32'd0 : 32'h5);
        mem_rresponse = 1'b1;
        #1;
        chk_eq("sim_second_resp", 32'({ibus_rresponse, dbus_rresponse}),
               first_is_dbus ? 32'd2 : 32'd1);
        tick();
        mem_rresponse = 1'b0;
        ibus_rrequest = 1'b0;
        dbus_rrequest = 1'b0;
        chk_eq("sim_end_rreq", 32'(mem_rrequest), 32'd0);

        // continuous ibus with dbus arriving mid-fetch
        ibus_address  = 32'h0000_0400;
        ibus_rrequest = 1'b1;
        tick();
        chk_eq("mid_ibus_addr", mem_address, 32'h0000_0400);
        dbus_address  = 32'h0000_5000;
        dbus_wdata    = 32'hCAFE_F00D;
        dbus_wstrobe  = 4'h3;
        dbus_wrequest = 1'b1;
        tick();
        chk_eq("mid_held_addr", mem_address, 32'h0000_0400);
        chk_eq("mid_held_wreq", 32'(mem_wrequest), 32'd0);
        mem_rresponse = 1'b1;
        #1;
        chk_eq("mid_ibus_resp", 32'(ibus_rresponse), 32'd1);
        chk_eq("mid_no_dbus_resp", 32'(dbus_wresponse), 32'd0);
        tick();
        mem_rresponse = 1'b0;
        ibus_address  = 32'h0000_0404;
        chk_eq("mid_dbus_wreq", 32'(mem_wrequest), 32'd1);
        chk_eq("mid_dbus_rreq", 32'(mem_rrequest), 32'd0);
        chk_eq("mid_dbus_addr", mem_address, 32'h0000_5000);
        chk_eq("mid_dbus_wstrobe", 32'(mem_wstrobe), 32'h3);
        mem_wresponse = 1'b1;
        #1;
        chk_eq("mid_dbus_wresp", 32'(dbus_wresponse), 32'd1);
        tick();
        mem_wresponse = 1'b0;
        dbus_wrequest = 1'b0;
        chk_eq("mid_back_ibus_addr", mem_address, 32'h0000_0404);
        chk_eq("mid_back_ibus_rreq", 32'(mem_rrequest), 32'd1);
        chk_eq("mid_back_ibus_wreq", 32'(mem_wrequest), 32'd0);
        mem_rresponse = 1'b1;
        tick();
        mem_rresponse = 1'b0;
        ibus_rrequest = 1'b0;
        chk_eq("mid_end_rreq", 32'(mem_rrequest), 32'd0);

        // reset while dbus busy, then a late write response
        dbus_address  = 32'h0000_6000;
        dbus_wdata    = 32'h0BAD_F00D;
        dbus_wstrobe  = 4'hC;
        dbus_wrequest = 1'b1;
        tick();
        chk_eq("rb_wreq_before", 32'(mem_wrequest), 32'd1);
        reset = 1'b1;
        #1;
        dbus_wrequest = 1'b0;
        chk_eq("rb_mem_wrequest", 32'(mem_wrequest), 32'd0);
        chk_eq("rb_mem_address", mem_address, 32'd0);
        chk_eq("rb_mem_wdata", mem_wdata, 32'd0);
        chk_eq("rb_mem_wstrobe", 32'(mem_wstrobe), 32'd0);
        chk_eq("rb_state", 32'(dut.state_q), ST_IDLE);
        tick();
        reset = 1'b0;
        tick();
        mem_wresponse = 1'b1;
        #1;
        chk_eq("rb_late_wresp", 32'(dbus_wresponse), 32'd0);
        tick();
        mem_wresponse = 1'b0;
        chk_eq("rb_state_after", 32'(dut.state_q), ST_IDLE);
        chk_eq("rb_wreq_after", 32'(mem_wrequest), 32'd0);

        // stray read response in IDLE
        mem_rresponse = 1'b1;
        mem_rdata     = 32'h5555_AAAA;
        #1;
        chk_eq("idle_resp", 32'({ibus_rresponse, dbus_rresponse, dbus_wresponse}), 32'd0);
        tick();
        mem_rresponse = 1'b0;
        chk_eq("idle_state", 32'(dut.state_q), ST_IDLE);
        chk_eq("idle_rreq", 32'(mem_rrequest), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
